match_score_tracker: RTL

- Downstream consumer of the matched-filter bank's per-shift score streams.
- Over one sweep of SWEEP_LENGTH score vectors, it tracks each filter's minimum score and the shift where that minimum occurred.
- At sweep end it selects the winning fingerprint, applying a confidence margin, then drives the LEDs and emits a framed 6-byte report to the UART transmitter.

---
 rtl/match_score_pkg.sv | 20 ++
 rtl/match_score_tracker_scan.sv | 78 +++++++
 rtl/match_score_tracker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/match_score_pkg.sv
// Shared types and constants for the match score tracker and its argmin scanner.
package match_score_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [7:0] REPORT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] NO_WINNER        = 8'hFF;
    localparam int         REPORT_LENGTH    = 6;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/match_score_tracker_scan.sv
// Sequential best/second/tie search over per-channel minima, one channel per cycle.
module score_argmin_scan
    import match_score_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int SCORE_WIDTH = 32,
    parameter int CH_W        = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             start,
    input  logic [NUM_FILTERS*SCORE_WIDTH-1:0] mins,
    output logic                             done,
    output logic [SCORE_WIDTH-1:0]           best_score,
    output logic [CH_W-1:0]                  best_idx,
    output logic [SCORE_WIDTH-1:0]           second_score,
    output logic                             second_valid,
    output logic                             tie
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_FILTERS - 1);

    logic                   busy;
    logic [CH_W-1:0]        idx;
    logic [SCORE_WIDTH-1:0] cur;

    always_comb begin
        cur = mins[int'(idx)*SCORE_WIDTH +: SCORE_WIDTH];
    end

    assign done = busy && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            idx          <= '0;
            best_score   <= '0;
            best_idx     <= '0;
            second_score <= '0;
            second_valid <= 1'b0;
            tie          <= 1'b0;
        end else if (clear) begin
            busy <= 1'b0;
            idx  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
        end else if (busy) begin
            if (idx == '0) begin
                best_score   <= cur;
                best_idx     <= '0;
                second_valid <= 1'b0;
                tie          <= 1'b0;
            end else if (cur < best_score) begin
                // Old best drops to runner-up; any earlier tie was on a worse score.
                second_score <= best_score;
                second_valid <= 1'b1;
                best_score   <= cur;
                best_idx     <= idx;
                tie          <= 1'b0;
            end else if (cur == best_score) begin
                tie          <= 1'b1;
                second_score <= cur;
                second_valid <= 1'b1;
            end else if (!second_valid || cur < second_score) begin
                second_score <= cur;
                second_valid <= 1'b1;
            end
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
            end else begin
                idx <= idx + CH_W'(1);
            end
        end
    end

endmodule

// File: rtl/match_score_tracker.sv
// Tracks per-filter minimum scores over a sweep, picks a winner with a margin,
// drives LEDs and serialises a 6-byte report to the UART.
//   state     | meaning
//   ST_ACCUM  | accept score vectors, update per-channel minima
//   ST_SCAN   | argmin scanner walks the channels, one per cycle
//   ST_DECIDE | apply tie/margin rule, latch decision outputs
//   ST_REPORT | send sync, winner and 4 score bytes, then restart sweep
module match_score_tracker
    import match_score_pkg::*;
#(
    parameter int NUM_FILTERS  = 4,
    parameter int SCORE_WIDTH  = 32,
    parameter int SWEEP_LENGTH = 2002,
    parameter logic [SCORE_WIDTH-1:0] MARGIN = '0,
    localparam int SHIFT_W = idx_width(SWEEP_LENGTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               axiiv,
    input  logic [NUM_FILTERS*SCORE_WIDTH-1:0] axiid,
    input  logic                               sweep_abort,
    output logic                               decision_valid,
    output logic [7:0]                         decision_winner,
    output logic [SCORE_WIDTH-1:0]             decision_score,
    output logic [SHIFT_W-1:0]                 decision_shift,
    output logic [15:0]                        led,
    output logic                               uart_axiiv,
    output logic [7:0]                         uart_axiid,
    input  logic                               uart_axiready
);

    localparam int CH_W = idx_width(NUM_FILTERS);

    state_t                            state, state_nxt;
    logic [SHIFT_W-1:0]                sweep_cnt;
    logic [SCORE_WIDTH-1:0]            min_score [NUM_FILTERS];
    logic [SHIFT_W-1:0]                min_shift [NUM_FILTERS];
    logic [NUM_FILTERS-1:0]            min_valid;
    logic [NUM_FILTERS*SCORE_WIDTH-1:0] mins_flat;
    logic [2:0]                        byte_idx;
    logic [NUM_FILTERS-1:0]            led_win;
    logic                              led_drop;

    logic                   accept, sweep_last, uart_fire, report_last;
    logic                   scan_done, second_valid, tie, winner_found;
    logic [SCORE_WIDTH-1:0] best_score, second_score;
    logic [CH_W-1:0]        best_idx;
    logic [SCORE_WIDTH:0]   margin_sum;
    logic [31:0]            score32;
    logic [7:0]             report_byte;

    assign accept      = (state == ST_ACCUM) && axiiv && !sweep_abort;
    assign sweep_last  = accept && (sweep_cnt == SHIFT_W'(SWEEP_LENGTH - 1));
    assign uart_fire   = (state == ST_REPORT) && uart_axiready && !uart_axiiv && !sweep_abort;
    assign report_last = uart_fire && (byte_idx == 3'(REPORT_LENGTH - 1));

    always_comb begin
        mins_flat = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            mins_flat[k*SCORE_WIDTH +: SCORE_WIDTH] = min_score[k];
        end
    end

    score_argmin_scan #(
        .NUM_FILTERS (NUM_FILTERS),
        .SCORE_WIDTH (SCORE_WIDTH),
        .CH_W        (CH_W)
    ) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (sweep_abort),
        .start        (sweep_last),
        .mins         (mins_flat),
        .done         (scan_done),
        .best_score   (best_score),
        .best_idx     (best_idx),
        .second_score (second_score),
        .second_valid (second_valid),
        .tie          (tie)
    );

    // Widened by one bit so best + MARGIN can never wrap past second.
    assign margin_sum   = {1'b0, best_score} + {1'b0, MARGIN};
    assign winner_found = (NUM_FILTERS == 1) ||
                          (!tie && second_valid && (margin_sum < {1'b0, second_score}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sweep_abort) begin
            state_nxt = ST_ACCUM;
        end else begin
            case (state)
                ST_ACCUM:  if (sweep_last)  state_nxt = ST_SCAN;
                ST_SCAN:   if (scan_done)   state_nxt = ST_DECIDE;
                ST_DECIDE:                  state_nxt = ST_REPORT;
                ST_REPORT: if (report_last) state_nxt = ST_ACCUM;
                default:                    state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt <= '0;
            min_valid <= '0;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                min_score[k] <= '0;
                min_shift[k] <= '0;
            end
        end else if (sweep_abort || report_last) begin
            sweep_cnt <= '0;
            min_valid <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                if (!min_valid[k] || (axiid[k*SCORE_WIDTH +: SCORE_WIDTH] < min_score[k])) begin
                    min_score[k] <= axiid[k*SCORE_WIDTH +: SCORE_WIDTH];
                    min_shift[k] <= sweep_cnt;
                end
            end
            min_valid <= '1;
            sweep_cnt <= sweep_cnt + SHIFT_W'(1);
        end
    end

    assign score32 = 32'(decision_score);

    always_comb begin
        report_byte = REPORT_SYNC_BYTE;
        case (byte_idx)
            3'd1:    report_byte = decision_winner;
            3'd2:    report_byte = score32[31:24];
            3'd3:    report_byte = score32[23:16];
            3'd4:    report_byte = score32[15:8];
            3'd5:    report_byte = score32[7:0];
            default: report_byte = REPORT_SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decision_valid  <= 1'b0;
            decision_winner <= '0;
            decision_score  <= '0;
            decision_shift  <= '0;
            led_win         <= '0;
            led_drop        <= 1'b0;
            uart_axiiv      <= 1'b0;
            uart_axiid      <= '0;
            byte_idx        <= '0;
        end else begin
            decision_valid <= 1'b0;
            if (!sweep_abort && state == ST_DECIDE) begin
                decision_valid  <= 1'b1;
                decision_winner <= winner_found ? 8'(best_idx) : NO_WINNER;
                decision_score  <= best_score;
                decision_shift  <= min_shift[best_idx];
                led_win         <= winner_found ? (NUM_FILTERS'(1) << best_idx) : '0;
            end
            if (axiiv && !sweep_abort && state != ST_ACCUM) begin
                led_drop <= 1'b1;
            end
            if (sweep_abort) begin
                uart_axiiv <= 1'b0;
                byte_idx   <= '0;
            end else begin
                uart_axiiv <= uart_fire;
                if (uart_fire) begin
                    uart_axiid <= report_byte;
                    byte_idx   <= report_last ? 3'd0 : byte_idx + 3'd1;
                end
            end
        end
    end

    always_comb begin
        led                  = '0;
        led[NUM_FILTERS-1:0] = led_win;
        led[15]              = led_drop;
    end

endmodule
